// File: rtl/ifetch_queue_ctrl.sv
// Instruction-fetch sequencer: drives the ROM address, captures returned words into a prefetch queue,
// and hands them to decode over valid/ready. The optional fetch/bubble counters are enabled by IFETCH_STATS_EN.
module ifetch_queue_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       hold,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
`ifdef IFETCH_STATS_EN
  output logic [15:0]                fetch_cnt,
  output logic [15:0]                bubble_cnt,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [31:0]         instr_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q    [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                push;
  logic                pop;

  // Redirect wins: any handshake or fetch in the redirect cycle is discarded.
  assign pop  = out_valid && out_ready && !redirect;
  assign push = (state == FETCH) && !redirect && ((count < CNT_W'(DEPTH)) || pop);

  assign rom_addr  = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  assign q_count   = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BOOT;
      fetch_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      case (state)
        BOOT:    state <= hold ? HOLD : FETCH;
        FETCH:   if (hold) state <= HOLD;
        HOLD:    if (!hold) state <= FETCH;
        default: state <= BOOT;
      endcase

      if (redirect) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else begin
        if (push) begin
          instr_q[wr_ptr] <= rom_data;
          pc_q[wr_ptr]    <= fetch_pc;
          wr_ptr          <= wr_ptr + 1'b1;
          fetch_pc        <= fetch_pc + ADDR_W'(4);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (push && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
      if (out_ready && !out_valid && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue_ctrl.sv
// Directed bench for ifetch_queue_ctrl: vector tables for boot/backpressure, hand sequences for
// redirect, PC wrap, hold and asynchronous reset.
module tb_ifetch_queue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        hold;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  ifetch_queue_ctrl #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // ROM: word at byte address 4k holds 0xA0000000 | k
  assign rom_data = 32'hA000_0000 | {26'd0, rom_addr[7:2]};

  typedef struct {
    logic        rdy;
    logic        hld;
    logic        v;
    logic [7:0]  pc;
    logic [31:0] ins;
    logic [2:0]  cnt;
    logic [7:0]  ra;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; hold = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
    step(); step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, q_count}, 32'd0);
    check("rst_pc", {24'd0, out_pc}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic check_head(input string name, input logic v, input logic [7:0] pc,
                            input logic [31:0] ins, input logic [2:0] cnt, input logic [7:0] ra);
    check({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({name, "_count"}, {29'd0, q_count}, {29'd0, cnt});
    check({name, "_rom_addr"}, {24'd0, rom_addr}, {24'd0, ra});
    if (v) begin
      check({name, "_pc"}, {24'd0, out_pc}, {24'd0, pc});
      check({name, "_instr"}, out_instr, ins);
    end
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      out_ready = vecs[i].rdy;
      hold      = vecs[i].hld;
      step();
      check_head($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].ins, vecs[i].cnt, vecs[i].ra);
    end
  endtask

  initial begin
    // Boot with out_ready = 1 (expected state after each edge following release)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h0,          3'd0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd1, 8'h04};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h04, 32'hA000_0001, 3'd1, 8'h08};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h08, 32'hA000_0002, 3'd1, 8'h0C};
    // Backpressure: fill to 4, freeze at 0x10, then drain in order
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,          3'd0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd1, 8'h04};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd2, 8'h08};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd3, 8'h0C};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd4, 8'h10};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd4, 8'h10};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd4, 8'h10};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd4, 8'h10};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd4, 8'h10};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'hA000_0000, 3'd4, 8'h10};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h04, 32'hA000_0001, 3'd4, 8'h14};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h08, 32'hA000_0002, 3'd4, 8'h18};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h0C, 32'hA000_0003, 3'd4, 8'h1C};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h10, 32'hA000_0004, 3'd4, 8'h20};

    do_reset();
    run_vecs(0, 3);
    do_reset();
    run_vecs(4, 17);

    // Redirect with three words queued
    do_reset();
    out_ready = 1'b0;
    step(); step(); step(); step();
    check_head("pre_redir", 1'b1, 8'h00, 32'hA000_0000, 3'd3, 8'h0C);
    redirect = 1'b1; redirect_pc = 8'h43;
    step();
    redirect = 1'b0;
    check_head("redir_flush", 1'b0, 8'h00, 32'h0, 3'd0, 8'h40);
    step();
    check_head("redir_first", 1'b1, 8'h40, 32'hA000_0010, 3'd1, 8'h44);

    // Redirect near the top of the ROM; PC wraps 0xFC -> 0x00
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hF8;
    step();
    redirect = 1'b0;
    check_head("wrap_flush", 1'b0, 8'h00, 32'h0, 3'd0, 8'hF8);
    step(); check_head("wrap_f8", 1'b1, 8'hF8, 32'hA000_003E, 3'd1, 8'hFC);
    step(); check_head("wrap_fc", 1'b1, 8'hFC, 32'hA000_003F, 3'd1, 8'h00);
    step(); check_head("wrap_00", 1'b1, 8'h00, 32'hA000_0000, 3'd1, 8'h04);
    step(); check_head("wrap_04", 1'b1, 8'h04, 32'hA000_0001, 3'd1, 8'h08);

    // Hold for 5 cycles: the entry cycle's fetch completes, then the queue drains
    hold = 1'b1;
    step(); check_head("hold_0", 1'b1, 8'h08, 32'hA000_0002, 3'd1, 8'h0C);
    for (int i = 1; i < 5; i++) begin
      step();
      check_head($sformatf("hold_%0d", i), 1'b0, 8'h00, 32'h0, 3'd0, 8'h0C);
    end
    hold = 1'b0;
    step(); check_head("unhold_0", 1'b0, 8'h00, 32'h0, 3'd0, 8'h0C);
    step(); check_head("unhold_1", 1'b1, 8'h0C, 32'hA000_0003, 3'd1, 8'h10);
    step(); check_head("unhold_2", 1'b1, 8'h10, 32'hA000_0004, 3'd1, 8'h14);

    // Asynchronous reset mid-burst, sampled before any further clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_count", {29'd0, q_count}, 32'd0);
    check("async_rom_addr", {24'd0, rom_addr}, 32'd0);
    step();
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue_ctrl.md
Name: ifetch_queue_ctrl

Overview:
Instruction-fetch sequencer for the 256-byte instruction ROM (rom256x8: 8-bit byte address in, 32-bit big-endian word out, combinational read).
- Owns the fetch PC and drives the ROM address every cycle.
- Captures each returned word into a small prefetch queue.
- Presents words to decode through a valid/ready handshake.
- Supports branch redirect (queue flush plus new PC) and a fetch-hold request from the pipeline.

Parameters:
ADDR_W, 8, ROM byte-address width; fetch PC width.
DEPTH, 4, prefetch queue entries; power of two, range 2..16.
RESET_PC, 0, first fetch address after reset; must be word-aligned.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
rom_addr  out  ADDR_W  byte address to ROM; always equals the fetch PC register, low 2 bits always 0.
rom_data  in  32  ROM word for rom_addr; valid in the same cycle.
hold  in  1  level request: stop issuing new fetches.
redirect  in  1  one-cycle pulse: flush and restart fetch.
redirect_pc  in  ADDR_W  new fetch address; low 2 bits ignored (forced to 0).
out_valid  out  1  queue head is valid.
out_ready  in  1  decode accepts the head this cycle.
out_instr  out  32  queue-head instruction.
out_pc  out  ADDR_W  byte address of out_instr.
q_count  out  clog2(DEPTH)+1  current queue occupancy.

Behaviour:
Reset (async assert, sync release):
- fetch_pc = RESET_PC, queue empty, q_count = 0, out_valid = 0.
- out_instr = 0, out_pc = 0, state = BOOT.

FSM:
- BOOT: exactly one cycle after reset release; rom_addr = RESET_PC, no push. Next state: FETCH, or HOLD if hold = 1.
- FETCH: push occurs when count < DEPTH, or when count == DEPTH and a pop happens the same cycle.
  - Push writes {rom_data, fetch_pc} at the tail, and fetch_pc += 4 modulo 2^ADDR_W (252 wraps to 0).
  - If the queue is full with no pop: no push and fetch_pc is held.
  - hold = 1 moves to HOLD; the push in that same cycle still completes.
- HOLD: no push, fetch_pc held. When hold = 0, return to FETCH on the next edge.

Pop:
- Pop occurs when out_valid && out_ready; the head advances.
- out_* are driven from the registered queue head, so there is no combinational path from rom_data to out_*.

Timing:
- Fetch-to-visible latency: a word pushed at edge N is on out_* with out_valid = 1 after edge N.
- Sustained throughput with out_ready = 1: 1 instruction per cycle.

Redirect (highest priority):
- At the edge: queue flushed (count = 0) and fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
- Any pop or push in that same cycle is discarded.
- The state keeps its FETCH/HOLD status; BOOT is unaffected.
- out_valid = 0 for the cycle after redirect; the first redirected word appears one edge later if fetching.
- Redirect during HOLD updates the PC and flushes; fetching starts when hold drops.

Other boundaries:
- Simultaneous push and pop at full: count unchanged.
- Simultaneous push and pop at empty: not possible; empty means no pop.
- Reset mid-operation: immediate return to reset values regardless of state.
- Pointers wrap modulo DEPTH.

Optional Feature:
IFETCH_STATS_EN
- Defined: adds outputs fetch_cnt[15:0] and bubble_cnt[15:0], both reset to 0 and saturating at 0xFFFF.
  - fetch_cnt increments on every push.
  - bubble_cnt increments each cycle out_ready = 1 && out_valid = 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Setup for all scenarios: ROM word at byte address 4k holds 0xA0000000|k.
2. Reset then out_ready = 1: first out_valid = 1 two edges after reset release, with out_pc = 0x00 / out_instr = 0xA0000000. Then 0x04 / 0xA0000001 and 0x08 / 0xA0000002 on consecutive cycles, no bubbles.
3. out_ready = 0 for 10 cycles after boot: q_count climbs 1,2,3,4 then stays 4. rom_addr freezes at 0x10. Releasing out_ready yields PCs 0x00, 0x04, 0x08, 0x0C, then 0x10, with no gap or duplicate.
4. Redirect pulse with redirect_pc = 0x43 while q_count = 3: next cycle q_count = 0 and out_valid = 0. Following cycle out_pc = 0x40, out_instr = 0xA0000010.
5. Redirect to 0xF8 with out_ready = 1: outputs PCs 0xF8, 0xFC, 0x00, 0x04 (wrap-around).
6. hold = 1 for 5 cycles in FETCH: rom_addr constant and no new pushes; the queue drains to 0. After hold drops, the next PC continues sequentially. Assert reset_n low mid-burst: out_valid = 0 and q_count = 0 immediately, without waiting for a clock edge.
